// File: rtl/md_unit_if.sv
// md_unit_if: EX-stage handshake and HI/LO bus between the pipeline and the multiply/divide unit
interface md_unit_if;
  logic        start;
  logic [3:0]  MDU_OP;
  logic [31:0] A;
  logic [31:0] B;
  logic        IntReq;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  modport master(output start, MDU_OP, A, B, IntReq, input busy, HI, LO);
  modport slave(input start, MDU_OP, A, B, IntReq, output busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers of the EX stage
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  md_unit_if.slave io
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [3:0] op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q, div_b, abs_a, abs_b, uq, ur, sq, sr;
  logic [63:0] res;
  logic launch, done, sgn, wr, idle_wr;
  always_comb begin
    launch = state == IDLE && io.start && !io.IntReq && io.MDU_OP >= 4'd1 && io.MDU_OP <= 4'd4;
    done = state == BUSY && cnt == CW'(1);
    state_d = launch ? BUSY : done ? IDLE : state;
    idle_wr = state == IDLE && !io.IntReq;
    sgn = op_q == 4'd4;
    // substitute divisor keeps the divider defined; the write is suppressed on zero anyway
    div_b = b_q == '0 ? 32'd1 : b_q;
    abs_a = sgn && a_q[31] ? -a_q : a_q;
    abs_b = sgn && div_b[31] ? -div_b : div_b;
    uq = abs_a / abs_b;
    ur = abs_a % abs_b;
    sq = sgn && (a_q[31] ^ b_q[31]) ? -uq : uq;
    sr = sgn && a_q[31] ? -ur : ur;
    res = op_q == 4'd1 ? {32'b0, a_q} * {32'b0, b_q} :
          op_q == 4'd2 ? {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q} : {sr, sq};
    wr = op_q <= 4'd2 || b_q != '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (launch) begin
        op_q <= io.MDU_OP;
        a_q  <= io.A;
        b_q  <= io.B;
        cnt  <= io.MDU_OP >= 4'd3 ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (state == BUSY) cnt <= cnt - CW'(1);
      if (done && wr) {hi_q, lo_q} <= res;
      else if (idle_wr && io.MDU_OP == 4'd5) hi_q <= io.A;
      else if (idle_wr && io.MDU_OP == 4'd6) lo_q <= io.A;
    end
  end
  assign io.busy = state == BUSY;
  assign io.HI = hi_q;
  assign io.LO = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit covering latency, arithmetic, flush and move-to behaviour
module tb_md_unit;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  md_unit_if io();
  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut(.clk(clk), .reset(reset), .io(io.slave));
  typedef struct {logic [3:0] op; logic [31:0] a; logic [31:0] b;} vec_t;
  int pass = 0, total = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 0, m_lo = 0;

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, b, input logic [63:0] cur);
    longint sa, sb2;
    int qa, qb;
    logic [63:0] ua, ub;
    logic [31:0] q, r;
    sa = longint'(signed'(a));
    sb2 = longint'(signed'(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    qa = a;
    qb = b;
    if (op == 4'd1) return ua * ub;
    if (op == 4'd2) return 64'(sa * sb2);
    if ((op == 4'd3 || op == 4'd4) && b == 0) return cur;
    if (op == 4'd3) return {a % b, a / b};
    if (op == 4'd4) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = 32'(qa / qb);
      r = 32'(qa % qb);
      return {r, q};
    end
    return cur;
  endfunction

  task automatic move(input logic [3:0] op, input logic [31:0] a, input logic irq);
    @(negedge clk);
    io.MDU_OP = op; io.A = a; io.IntReq = irq;
    @(negedge clk);
    io.MDU_OP = 0; io.IntReq = 0;
    if (!irq) begin
      if (op == 4'd5) m_hi = a;
      else m_lo = a;
    end
  endtask

  // launches one op, scrambles operands afterwards and optionally injects a stray input on busy cycle inj_at
  task automatic run(input logic [3:0] op, input logic [31:0] a, b, input logic irq, input int inj_at,
                     input logic inj_start, input logic [3:0] inj_op, input logic inj_irq, output int n);
    @(negedge clk);
    io.start = 1; io.MDU_OP = op; io.A = a; io.B = b; io.IntReq = irq;
    exp_q.push_back(irq ? {m_hi, m_lo} : model(op, a, b, {m_hi, m_lo}));
    @(negedge clk);
    io.start = 0; io.MDU_OP = 0; io.IntReq = 0; io.A = ~a; io.B = b + 32'd3;
    n = 0;
    while (io.busy && n < 100) begin
      n++;
      io.start = n == inj_at && inj_start;
      io.MDU_OP = n == inj_at ? inj_op : 4'd0;
      io.IntReq = n == inj_at && inj_irq;
      io.A = n == inj_at ? 32'h99 : io.A;
      @(negedge clk);
    end
    io.start = 0; io.MDU_OP = 0; io.IntReq = 0;
  endtask

  task automatic test_reset;
    #1 reset = 1;
    #2;
    total += 3;
    if (io.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", io.busy); else pass++;
    if (io.HI !== 32'h0) $display("FAIL reset_hi got %h want 0", io.HI); else pass++;
    if (io.LO !== 32'h0) $display("FAIL reset_lo got %h want 0", io.LO); else pass++;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_mult;
    vec_t v[4] = '{'{4'd2, 32'hFFFF_FFFE, 32'h3}, '{4'd1, 32'hFFFF_FFFE, 32'h3},
                   '{4'd2, 32'h7FFF_FFFF, 32'h8000_0000}, '{4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF}};
    int n;
    logic [63:0] e;
    foreach (v[i]) begin
      run(v[i].op, v[i].a, v[i].b, 0, 0, 0, 0, 0, n);
      e = exp_q.pop_front();
      {m_hi, m_lo} = e;
      total += 2;
      if (n !== 5) $display("FAIL mult_latency[%0d] got %0d want 5", i, n); else pass++;
      if ({io.HI, io.LO} !== e) $display("FAIL mult_result[%0d] got %h want %h", i, {io.HI, io.LO}, e); else pass++;
    end
  endtask

  task automatic test_div;
    vec_t v[5] = '{'{4'd4, 32'hFFFF_FFF9, 32'h2}, '{4'd3, 32'h7, 32'h2}, '{4'd4, 32'h7, 32'hFFFF_FFFE},
                   '{4'd3, 32'hFFFF_FFFF, 32'h10}, '{4'd4, 32'h8000_0000, 32'hFFFF_FFFF}};
    int n;
    logic [63:0] e;
    foreach (v[i]) begin
      run(v[i].op, v[i].a, v[i].b, 0, 0, 0, 0, 0, n);
      e = exp_q.pop_front();
      {m_hi, m_lo} = e;
      total += 2;
      if (n !== 10) $display("FAIL div_latency[%0d] got %0d want 10", i, n); else pass++;
      if ({io.HI, io.LO} !== e) $display("FAIL div_result[%0d] got %h want %h", i, {io.HI, io.LO}, e); else pass++;
    end
  endtask

  task automatic test_div_zero;
    int n;
    logic [63:0] e;
    move(4'd5, 32'h11, 0);
    move(4'd6, 32'h22, 0);
    run(4'd4, 32'h5, 32'h0, 0, 3, 0, 4'd6, 0, n);
    e = exp_q.pop_front();
    total += 3;
    if (n !== 10) $display("FAIL divzero_latency got %0d want 10", n); else pass++;
    if ({io.HI, io.LO} !== e) $display("FAIL divzero_result got %h want %h", {io.HI, io.LO}, e); else pass++;
    if (io.LO !== 32'h22) $display("FAIL mtlo_in_busy got %h want 22", io.LO); else pass++;
    run(4'd3, 32'h9, 32'h0, 0, 4, 0, 4'd5, 0, n);
    e = exp_q.pop_front();
    total += 2;
    if (n !== 10) $display("FAIL divuzero_latency got %0d want 10", n); else pass++;
    if (io.HI !== 32'h11) $display("FAIL mthi_in_busy got %h want 11", io.HI); else pass++;
  endtask

  task automatic test_intreq;
    int n;
    logic [63:0] e;
    run(4'd2, 32'h5, 32'h6, 1, 0, 0, 0, 0, n);
    e = exp_q.pop_front();
    total += 2;
    if (n !== 0) $display("FAIL flushed_busy got %0d want 0", n); else pass++;
    if ({io.HI, io.LO} !== e) $display("FAIL flushed_result got %h want %h", {io.HI, io.LO}, e); else pass++;
    run(4'd2, 32'hFFFF_FFF0, 32'h1234, 0, 2, 0, 0, 1, n);
    e = exp_q.pop_front();
    {m_hi, m_lo} = e;
    total += 2;
    if (n !== 5) $display("FAIL irq_mid_latency got %0d want 5", n); else pass++;
    if ({io.HI, io.LO} !== e) $display("FAIL irq_mid_result got %h want %h", {io.HI, io.LO}, e); else pass++;
    run(4'd1, 32'h0001_0000, 32'h0003_0000, 0, 2, 1, 4'd4, 0, n);
    e = exp_q.pop_front();
    {m_hi, m_lo} = e;
    total += 2;
    if (n !== 5) $display("FAIL stray_start_latency got %0d want 5", n); else pass++;
    if ({io.HI, io.LO} !== e) $display("FAIL stray_start_result got %h want %h", {io.HI, io.LO}, e); else pass++;
  endtask

  task automatic test_move;
    move(4'd5, 32'hDEAD_BEEF, 0);
    total += 2;
    if (io.HI !== m_hi) $display("FAIL mthi got %h want %h", io.HI, m_hi); else pass++;
    if (io.busy !== 1'b0) $display("FAIL mthi_busy got %b want 0", io.busy); else pass++;
    move(4'd6, 32'h1234_5678, 1);
    total++;
    if (io.LO !== m_lo) $display("FAIL mtlo_irq got %h want %h", io.LO, m_lo); else pass++;
    move(4'd6, 32'hCAFE_F00D, 0);
    total++;
    if (io.LO !== m_lo) $display("FAIL mtlo got %h want %h", io.LO, m_lo); else pass++;
  endtask

  task automatic test_reset_mid;
    move(4'd5, 32'hAAAA_5555, 0);
    move(4'd6, 32'h5555_AAAA, 0);
    @(negedge clk);
    io.start = 1; io.MDU_OP = 4'd2; io.A = 32'h3; io.B = 32'h4;
    @(negedge clk);
    io.start = 0; io.MDU_OP = 0;
    @(negedge clk);
    #2 reset = 1;
    #1;
    total += 3;
    if (io.busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", io.busy); else pass++;
    if (io.HI !== 32'h0) $display("FAIL midreset_hi got %h want 0", io.HI); else pass++;
    if (io.LO !== 32'h0) $display("FAIL midreset_lo got %h want 0", io.LO); else pass++;
    @(negedge clk);
    reset = 0;
    m_hi = 0; m_lo = 0;
    repeat (8) @(negedge clk);
    total += 2;
    if (io.busy !== 1'b0) $display("FAIL postreset_busy got %b want 0", io.busy); else pass++;
    if ({io.HI, io.LO} !== 64'h0) $display("FAIL postreset_result got %h want 0", {io.HI, io.LO}); else pass++;
  endtask

  initial begin
    io.start = 0; io.MDU_OP = 0; io.A = 0; io.B = 0; io.IntReq = 0;
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_intreq;
    test_move;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the P7 pipeline.
- Consumes the start strobe and 4-bit MDU opcode decoded by the ID/EX stage register, plus the forwarded EX operands.
- Holds the HI/LO architectural registers and drives busy, which the hazard unit uses to stall mfhi/mflo/mthi/mtlo/mult/div.
- Drives mfhi/mflo read data to the EX result mux.

Parameters:
- MULT_CYCLES, 5: busy duration for mult/multu, in cycles.
- DIV_CYCLES, 10: busy duration for div/divu, in cycles.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: launch mult/multu/div/divu this cycle.
- MDU_OP, input, 4: 0 none, 1 multu, 2 mult, 3 divu, 4 div, 5 mthi, 6 mtlo, others none.
- A, input, 32: rs operand, forwarded.
- B, input, 32: rt operand, forwarded.
- IntReq, input, 1: exception/interrupt taken this cycle; the EX instruction is being flushed.
- busy, output, 1: operation in progress.
- HI, output, 32: HI register.
- LO, output, 32: LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - State goes to IDLE; counter = 0.
  - HI = 0, LO = 0, busy = 0.
  - Any pending result is discarded.
- States:
  - IDLE: busy = 0.
  - BUSY: busy = 1, down-counter cnt active.
- Launch condition: start=1 and IntReq=0 and state IDLE, sampled at edge t.
  - Latch A, B and MDU_OP into internal registers.
  - cnt is loaded with MULT_CYCLES for ops 1/2, or DIV_CYCLES for ops 3/4.
  - State goes to BUSY.
  - busy is high from just after edge t for exactly N cycles. It is high when sampled at edges t+1 … t+N and low at t+N+1.
- In BUSY, cnt decrements each edge.
  - At the edge where cnt reaches 1, HI/LO are written and the state returns to IDLE.
  - New HI/LO are visible in the same cycle busy falls.
- start with an opcode other than 1–4 is ignored.
- start while BUSY is ignored. The hazard unit guarantees this never happens; the bench checks that state and results are unaffected.
- IntReq=1 together with start: the launch is suppressed (the instruction is flushed), and HI/LO are unchanged.
- IntReq during BUSY does not abort: the operation belongs to an older, committed instruction and completes normally.
- mthi/mtlo (op 5/6) in IDLE with IntReq=0:
  - HI←A (op 5) or LO←A (op 6) at the next edge; busy stays 0.
  - In BUSY, or with IntReq=1, the write is ignored.
  - These ops do not require start.
- Arithmetic on the latched operands:
  - multu: {HI,LO} = zero-extend(A) × zero-extend(B), 64 bits.
  - mult: {HI,LO} = signed product, 64 bits.
  - divu: LO = A/B, HI = A%B, unsigned.
  - div: signed, quotient truncated toward zero; HI carries the sign of the dividend.
  - Divisor 0, div or divu: the full latency still elapses and HI/LO stay unchanged.
  - div of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- HI/LO outputs are the registers directly; there is no combinational path from A/B.
- Operand changes after launch have no effect on the result.

Test Plan:
- Reset mid-operation: reset asserted mid-cycle while a mult is BUSY → busy, HI and LO drop to 0 immediately, without waiting for a clock edge; after release, the state is IDLE.
- Signed multiply: mult, A=0xFFFFFFFE (−2), B=0x00000003 → busy high for 5 sampled edges, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat with multu on the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- Signed divide: div, A=0xFFFFFFF9 (−7), B=2 → busy for 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Unsigned divide: divu, A=7, B=2 → LO=3, HI=1.
- Divide by zero: preload HI=0x11, LO=0x22 via mthi/mtlo, then div with B=0 → busy for 10 cycles; HI=0x11, LO=0x22 unchanged. With A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- IntReq and stray starts:
  - start+mult with IntReq=1 → busy stays 0, HI/LO unchanged.
  - Mid-mult, assert IntReq at cycle 2 → the mult completes at cycle 5 with the correct result.
  - Mid-mult, issue start+div → ignored; final result is the mult's.
- Move-to and operand latching:
  - mthi A=0xDEADBEEF in IDLE → HI=0xDEADBEEF next edge, busy=0.
  - mtlo during BUSY → LO unaffected.
  - Changing A/B after launch → result unaffected.
